// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // RV32I load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane enables for an access; undefined encodings behave as words.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            F3_B, F3_BU: be = 4'b0001 << a;
            F3_H, F3_HU: be = a[1] ? 4'b1100 : 4'b0011;
            default:     be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational load extract/extend and store lane replication/byte enables.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] mem_word,
    output logic [31:0] ld_data,
    output logic [31:0] st_data,
    output logic [3:0]  be,
    output logic        misaligned
);

    logic [1:0]  off;
    logic [31:0] shifted;

    // Select the addressed lane, extend loads, replicate store data across lanes
    always_comb begin
        off        = 2'b00;
        ld_data    = mem_word;
        st_data    = wr_data;
        misaligned = 1'b0;
        case (funct3)
            F3_B, F3_BU: off = addr_lo;
            F3_H, F3_HU: off = {addr_lo[1], 1'b0};
            default:     off = 2'b00;
        endcase
        shifted = mem_word >> {off, 3'b000};
        case (funct3)
            F3_B: begin
                ld_data = {{24{shifted[7]}}, shifted[7:0]};
                st_data = {4{wr_data[7:0]}};
            end
            F3_BU: begin
                ld_data = {24'h000000, shifted[7:0]};
                st_data = {4{wr_data[7:0]}};
            end
            F3_H: begin
                ld_data    = {{16{shifted[15]}}, shifted[15:0]};
                st_data    = {2{wr_data[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_HU: begin
                ld_data    = {16'h0000, shifted[15:0]};
                st_data    = {2{wr_data[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                ld_data    = mem_word;
                st_data    = wr_data;
                misaligned = |addr_lo;
            end
        endcase
        be = lane_be(funct3, addr_lo);
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and RV32I sub-word access.
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam int CNT_W = (WAIT_CYC < 1) ? 1 : $clog2(WAIT_CYC + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] op_addr;
    logic [2:0]        op_f3;
    logic [DATA_W-1:0] op_wd;
    logic              op_wr;
    logic              op_ld;

    logic [DATA_W-1:0] mem [0:WORDS-1] = '{default: '0};

    logic [ADDR_W-1:0] acc_addr;
    logic [2:0]        acc_f3;
    logic [DATA_W-1:0] acc_wd;
    logic              acc_ld;
    logic [DATA_W-1:0] mem_word;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_data;
    logic [3:0]        be;
    logic              misaligned;
    logic              trap;
    logic              enter_resp;

    // With no wait states RESP is entered on the accepting edge, so the
    // datapath must look at the live request rather than the latched copy.
    always_comb begin
        acc_addr = op_addr;
        acc_f3   = op_f3;
        acc_wd   = op_wd;
        acc_ld   = op_ld;
        if (state == IDLE) begin
            acc_addr = addr;
            acc_f3   = funct3;
            acc_wd   = wr_data;
            acc_ld   = rd & ~wr;
        end
        mem_word   = mem[acc_addr[ADDR_W-1:2]];
        enter_resp = ((state == IDLE) && (rd | wr) && (WAIT_CYC == 0)) ||
                     ((state == WAIT) && (cnt == CNT_W'(WAIT_CYC)));
    end

    dmem_lane_align u_align (
        .funct3     (acc_f3),
        .addr_lo    (acc_addr[1:0]),
        .wr_data    (acc_wd),
        .mem_word   (mem_word),
        .ld_data    (ld_data),
        .st_data    (st_data),
        .be         (be),
        .misaligned (misaligned)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = misaligned;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
    assign trap = 1'b0;
`endif

    // Request FSM with registered ready/busy/err/rd_data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_data <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            op_addr <= '0;
            op_f3   <= '0;
            op_wd   <= '0;
            op_wr   <= 1'b0;
            op_ld   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd | wr) begin
                        op_addr <= addr;
                        op_f3   <= funct3;
                        op_wd   <= wr_data;
                        op_wr   <= wr;
                        op_ld   <= rd & ~wr;
                        busy    <= 1'b1;
                        if (WAIT_CYC == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(WAIT_CYC)) begin
                        state <= RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                ready <= 1'b1;
                err   <= trap;
                if (acc_ld && !trap) rd_data <= ld_data;
            end
        end
    end

    // Store commit on the edge leaving RESP
    always_ff @(posedge clk) begin
        if ((state == RESP) && op_wr && !trap) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[op_addr[ADDR_W-1:2]][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one WAIT_CYC=2 and one WAIT_CYC=0 instance.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s  [2];
    logic        rd_s   [2];
    logic        wr_s   [2];
    logic [8:0]  addr_s [2];
    logic [2:0]  f3_s   [2];
    logic [31:0] wd_s   [2];
    logic [31:0] rdd_s  [2];
    logic        rdy_s  [2];
    logic        busy_s [2];
    logic        err_s  [2];

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(2)) dut0 (
        .clk(clk), .reset(rst_s[0]), .rd(rd_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
        .funct3(f3_s[0]), .wr_data(wd_s[0]), .rd_data(rdd_s[0]), .ready(rdy_s[0]),
        .busy(busy_s[0]), .err(err_s[0])
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) dut1 (
        .clk(clk), .reset(rst_s[1]), .rd(rd_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
        .funct3(f3_s[1]), .wr_data(wd_s[1]), .rd_data(rdd_s[1]), .ready(rdy_s[1]),
        .busy(busy_s[1]), .err(err_s[1])
    );

    int checks = 0;
    int fails  = 0;

    // Reference model: byte-addressed memory and last load result per unit
    logic [7:0]  mm  [2][512];
    logic [31:0] rdm [2];

    function automatic int wc(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input int u, input bit r, input bit w, input logic [8:0] a,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err);
        int     size;
        bit     sgn;
        int     base;
        bit     mis;
        longint v;
        size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        sgn  = (f3 == 3'd0 || f3 == 3'd1);
        mis  = (int'(a) % size) != 0;
        base = int'(a) - (int'(a) % size);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_err = mis;
`else
        exp_err = 1'b0;
`endif
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < size; i++) mm[u][base + i] = wd[8*i +: 8];
            end else if (r) begin
                v = 0;
                for (int i = 0; i < size; i++) v += longint'(mm[u][base + i]) << (8 * i);
                if (sgn && v >= (64'sd1 << (8 * size - 1))) v -= (64'sd1 << (8 * size));
                rdm[u] = v[31:0];
            end
        end
        exp_rd = rdm[u];
    endtask

    task automatic txn(input int u, input bit r, input bit w, input logic [8:0] a,
                       input logic [2:0] f3, input logic [31:0] wd, input string tag);
        logic [31:0] er;
        logic        ee;
        int          cyc;
        int          bcnt;
        @(negedge clk);
        rd_s[u] = r; wr_s[u] = w; addr_s[u] = a; f3_s[u] = f3; wd_s[u] = wd;
        @(posedge clk); #1;
        // Request fields change while pending; only the latched copy matters
        addr_s[u] = 9'($urandom_range(0, 511));
        f3_s[u]   = 3'($urandom_range(0, 7));
        wd_s[u]   = $urandom;
        cyc  = 1;
        bcnt = busy_s[u] ? 1 : 0;
        while (!rdy_s[u] && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (busy_s[u]) bcnt++;
        end
        rd_s[u] = 1'b0; wr_s[u] = 1'b0;
        model(u, r, w, a, f3, wd, er, ee);
        check({tag, "/latency"}, 32'(cyc), 32'(wc(u) + 1));
        check({tag, "/busy_cycles"}, 32'(bcnt), 32'(wc(u) + 1));
        check({tag, "/rd_data"}, rdd_s[u], er);
        check({tag, "/err"}, {31'd0, err_s[u]}, {31'd0, ee});
        @(posedge clk); #1;
        check({tag, "/ready_drop"}, {31'd0, rdy_s[u]}, 32'd0);
        check({tag, "/busy_drop"}, {31'd0, busy_s[u]}, 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_s[u] = 1'b1; rd_s[u] = 1'b0; wr_s[u] = 1'b0;
            addr_s[u] = '0; f3_s[u] = '0; wd_s[u] = '0; rdm[u] = '0;
            for (int i = 0; i < 512; i++) mm[u][i] = 8'h00;
        end
        #2;
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        #10;
        check("reset/rd_data", rdd_s[0], 32'd0);
        check("reset/ready", {31'd0, rdy_s[0]}, 32'd0);
        check("reset/busy", {31'd0, busy_s[0]}, 32'd0);
        check("reset/err", {31'd0, err_s[0]}, 32'd0);
        check("reset1/rd_data", rdd_s[1], 32'd0);
        @(negedge clk);
        rst_s[0] = 1'b1; rst_s[1] = 1'b1;

        // Directed sequence, WAIT_CYC=2
        txn(0, 0, 1, 9'h010, 3'b010, 32'hDEADBEEF, "sw010");
        txn(0, 1, 0, 9'h010, 3'b010, 32'h0, "lw010");
        check("lw010/const", rdd_s[0], 32'hDEADBEEF);
        txn(0, 0, 1, 9'h013, 3'b000, 32'h000000A5, "sb013");
        txn(0, 1, 0, 9'h013, 3'b000, 32'h0, "lb013");
        check("lb013/const", rdd_s[0], 32'hFFFFFFA5);
        txn(0, 1, 0, 9'h013, 3'b100, 32'h0, "lbu013");
        check("lbu013/const", rdd_s[0], 32'h000000A5);
        txn(0, 1, 0, 9'h010, 3'b010, 32'h0, "lw010b");
        check("lw010b/const", rdd_s[0], 32'hA5ADBEEF);
        txn(0, 1, 0, 9'h012, 3'b001, 32'h0, "lh012");
        check("lh012/const", rdd_s[0], 32'hFFFFA5AD);
        txn(0, 0, 1, 9'h012, 3'b001, 32'h00001234, "sh012");
        txn(0, 1, 0, 9'h012, 3'b101, 32'h0, "lhu012");
        check("lhu012/const", rdd_s[0], 32'h00001234);
        txn(0, 1, 0, 9'h010, 3'b010, 32'h0, "lw010c");
        check("lw010c/const", rdd_s[0], 32'h1234BEEF);
        txn(0, 1, 1, 9'h030, 3'b010, 32'hCAFEF00D, "rdwr030");
        check("rdwr030/const", rdd_s[0], 32'h1234BEEF);
        txn(0, 1, 0, 9'h030, 3'b010, 32'h0, "lw030");
        check("lw030/const", rdd_s[0], 32'hCAFEF00D);
        txn(0, 1, 0, 9'h011, 3'b010, 32'h0, "lw011");
`ifdef DMEM_MISALIGN_TRAP_EN
        check("lw011/const", rdd_s[0], 32'hCAFEF00D);
`else
        check("lw011/const", rdd_s[0], 32'h1234BEEF);
`endif

        // Reset pulsed while a store waits
        @(negedge clk);
        wr_s[0] = 1'b1; addr_s[0] = 9'h020; f3_s[0] = 3'b010; wd_s[0] = 32'h11111111;
        @(posedge clk); #1;
        check("rst_mid/busy_before", {31'd0, busy_s[0]}, 32'd1);
        #2;
        rst_s[0] = 1'b0;
        #1;
        check("rst_mid/ready", {31'd0, rdy_s[0]}, 32'd0);
        check("rst_mid/busy", {31'd0, busy_s[0]}, 32'd0);
        wr_s[0] = 1'b0;
        @(negedge clk);
        rst_s[0] = 1'b1;
        rdm[0] = 32'd0;
        check("rst_mid/rd_data", rdd_s[0], 32'd0);
        txn(0, 1, 0, 9'h020, 3'b010, 32'h0, "lw020");
        check("lw020/const", rdd_s[0], 32'h00000000);

        // Directed, WAIT_CYC=0
        txn(1, 0, 1, 9'h010, 3'b010, 32'hDEADBEEF, "u1_sw010");
        txn(1, 1, 0, 9'h010, 3'b010, 32'h0, "u1_lw010");
        check("u1_lw010/const", rdd_s[1], 32'hDEADBEEF);

        // Randomized traffic against the model on both instances
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 40; n++) begin
                int op;
                op = $urandom_range(0, 2);
                txn(u, op != 1, op != 0, 9'($urandom_range(0, 511)),
                    3'($urandom_range(0, 7)), $urandom, $sformatf("rnd%0d_%0d", u, n));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the core's load/store port (wr, rd, addr, wr_data, rd_data).
- Accepts one request at a time, inserts WAIT_CYC programmable wait states, then completes with a one-cycle ready pulse.
- Handles RV32I sub-word loads and stores (byte/half/word, signed or unsigned) against a word-organised internal array.
- Instantiated beside the riscv top in the testbench/SoC wrapper.

Parameters:
- DATA_W, 32, data word width; only 32 is supported.
- ADDR_W, 9, byte-address width (512 B, i.e. 128 words).
- WAIT_CYC, 2, number of wait-state cycles before ready; 0 is legal.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous reset, active-low (asserted when 0).
- rd  input  1  load request; held by the core until ready.
- wr  input  1  store request; held by the core until ready.
- addr  input  ADDR_W  byte address.
- funct3  input  3  access size/sign (RV32I load/store funct3).
- wr_data  input  DATA_W  store data, right-justified.
- rd_data  output  DATA_W  load result, sign/zero extended.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from request acceptance until ready (inclusive).
- err  output  1  misaligned-access flag; valid only with ready (see Optional Feature).

Behaviour:
- Reset values (reset=0): state IDLE, wait counter 0, rd_data 0, ready 0, busy 0, err 0.
  - Array contents are not reset; they are zero-initialised at elaboration only.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a clock edge with rd|wr high, latch addr, funct3, wr_data and the operation, then go to WAIT. If WAIT_CYC=0, go directly to RESP.
  - WAIT: counter counts 1..WAIT_CYC; go to RESP when it reaches WAIT_CYC.
  - RESP: ready=1 for exactly one cycle, then unconditionally return to IDLE. A new request is sampled no earlier than the following edge.
- Latency: ready asserts WAIT_CYC+1 cycles after the accepting edge. busy is high during WAIT and RESP.
- Request ports are sampled only in IDLE. Changes to them during WAIT/RESP are ignored, because all values used are the latched copies.
- rd and wr both high: the request is treated as a store; no read is performed and rd_data is unchanged.
- Store commit: on the edge that leaves RESP, using per-byte write enables.
  - SB writes lane addr[1:0] with wr_data[7:0].
  - SH writes lanes {addr[1],0}+1..0 with wr_data[15:0].
  - SW writes all four lanes.
- Load: the word is read and lane-aligned; rd_data updates on the edge entering RESP and holds until the next completed load.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is the full word.
- Undefined funct3 (011, 110, 111): treated as a word access.
- Word index = addr[ADDR_W-1:2]; there is no wrap or out-of-range case because the whole address space is backed.
- Reset mid-operation: the FSM returns to IDLE immediately, the pending store is discarded (no partial write), and ready/busy drop asynchronously.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - A halfword with addr[0]=1, or a word with addr[1:0]!=0, completes normally with ready but with err=1.
  - The store is suppressed and rd_data is unchanged.
- Undefined:
  - err is tied to 0.
  - Low address bits are force-aligned (halfword clears addr[0], word clears addr[1:0]) and the access proceeds.

Decomposition:
- Package dmem_pkg:
  - state enum (IDLE/WAIT/RESP);
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101);
  - the lane byte-enable function.
- Sub-module dmem_lane_align: combinational load extract/extend plus store lane replication and byte-enable generation. Keeps the FSM file free of datapath.

Test Plan:
- WAIT_CYC=2: SW 0x010 with 0xDEADBEEF → ready exactly 3 cycles after acceptance. Then LW 0x010 → rd_data=0xDEADBEEF, busy high for 3 cycles.
- SB 0x013 with 0x000000A5 → LB 0x013 = 0xFFFFFFA5; LBU 0x013 = 0x000000A5; LW 0x010 = 0xA5ADBEEF.
- LH 0x012 → 0xFFFFA5AD. Then SH 0x012 with 0x00001234 → LW 0x010 = 0x1234BEEF; LHU 0x012 = 0x00001234.
- SW 0x020 with 0x11111111, reset pulsed low during WAIT → ready/busy go 0 at once. After release, LW 0x020 = 0x00000000.
- rd and wr both high, SW-type to 0x030 with 0xCAFEF00D, with rd_data previously 0x1234BEEF → store occurs, rd_data stays 0x1234BEEF. LW 0x030 = 0xCAFEF00D.
- Misaligned LW 0x011:
  - With DMEM_MISALIGN_TRAP_EN: ready=1, err=1, rd_data unchanged.
  - Without it: rd_data = word at 0x010, err=0.
  - Also rerun with WAIT_CYC=0: back-to-back requests each complete 1 cycle after acceptance.
